cdc_mcp_pacer: RTL and testbench
================================

# cdc_mcp_pacer

Source-side pacing stage for the synchronized-enable-pulse multi-cycle-path (MCP) crossing. It runs entirely in the sending clock domain and accepts a valid/ready word stream into a small FIFO. It drives the crossing's `adata`/`aen` inputs, emitting at most one single-cycle enable every `GAP` cycles with `adata` held stable between enables, so the destination always samples settled data. An optional mode also waits for a returned acknowledge toggle before each launch.

## Interface
- `DW`, 8: data width, ≥1.
- `DEPTH`, 4: FIFO entries; power of 2, ≥2.
- `GAP`, 6: minimum aclk cycles from one `aen` pulse to the next, ≥2.
- `aclk`  in  1  sending-domain clock; everything is on its rising edge.
- `arst_n`  in  1  reset, asynchronous assert, active-low.
- `s_data`  in  DW  upstream word.
- `s_valid`  in  1  upstream word valid.
- `s_ready`  out  1  FIFO can accept a word.
- `adata`  out  DW  word presented to the crossing; registered.
- `aen`  out  1  single-cycle launch pulse; registered.
- `level`  out  $clog2(DEPTH)+1  words currently queued, excluding the launched word.
- `inflight`  out  1  a launch is not yet permitted to be followed (gap counting or, in ACK mode, awaiting ack).
- `back_tgl`  in  1  destination acknowledge toggle, asynchronous to aclk. Present only with `CDC_MCP_PACER_ACK_EN`.

## Operation
- **Reset values** (`arst_n` low, asynchronous): `aen`=0, `adata`=0, `level`=0, `inflight`=0, `s_ready`=0.
  - Gap counter = 0; FIFO pointers = 0.
  - ACK state: `busy`=0, sync flops = 0, `ack_seen`=0.
  - `s_ready` rises on the first edge after `arst_n` deasserts.
- **Push:** `s_valid && s_ready` at an edge writes `s_data` at the write pointer. `s_ready` = !full.
- **Launch condition (edge-sampled):** FIFO non-empty && gap counter == 0 && (ACK mode ? !busy : 1).
- **Launch:**
  - Head word registered into `adata`; read pointer advances; `aen`=1 for exactly one cycle.
  - Gap counter loads `GAP-1`.
- **Gap counter:** decrements by 1 each cycle while non-zero; saturates at 0.
- **`inflight`** = (counter != 0) || busy.
- **`adata` stability:** changes only on a launch edge. It is stable for ≥`GAP` cycles after each `aen`.
- **Simultaneous push and launch:** `level` unchanged.
  - Push to an empty FIFO cannot launch on the same edge; no fall-through.
  - When full, `s_ready`=0, so no push occurs even if a launch frees a slot that edge. `s_ready` rises the following cycle.
- **Pointers:** `$clog2(DEPTH)+1` bits; wrap modulo 2·DEPTH. Full = MSBs differ and lower bits equal.
- **Idle:** `aen`=0 while the FIFO is empty. `adata` keeps the last launched word.

## Timing
- **Word into empty FIFO, counter 0:** accepted at edge k; `aen` high in the cycle after edge k+1. Latency is 1 cycle.
- **Back-to-back launches:** `aen` edges exactly `GAP` cycles apart when the FIFO is non-empty and not in ACK mode. Sustained throughput is 1 word per `GAP` cycles.
- **Max acceptance:** `DEPTH` words with no launch, then `s_ready` low.
- **Reset mid-operation:**
  - Queued words are discarded; `aen` drops immediately (asynchronously).
  - No partial pulse is generated after release.

## Configuration
- **`CDC_MCP_PACER_ACK_EN` defined:**
  - Port `back_tgl` exists and is passed through a 2-flop synchronizer.
  - A launch sets `busy`=1.
  - `busy` clears on the edge after the synchronized toggle differs from `ack_seen`; `ack_seen` then takes the synchronized value.
  - Launch needs both gap expired and `busy`=0. A toggle arriving while not `busy` is absorbed into `ack_seen` with no effect.
- **Not defined:**
  - No `back_tgl` port and no synchronizer; `busy` is constant 0.
  - Pacing is purely by `GAP`.

## Test plan
- **Reset release, single word:** push 0xA5 at edge 3.
  - `aen` pulses exactly once, one cycle wide, in cycle 4→5.
  - `adata`=0xA5 and stays 0xA5 afterwards; `level` returns to 0.
- **Burst fill, default params:** drive `s_valid` continuously with 0x01..0x08.
  - `s_ready` drops after 5 accepted (4 queued + 1 launched).
  - `aen` pulses every 6 cycles, and `adata` sequence is 0x01..0x08 in order with no loss or duplication.
- **Wrap-around:** stream 20 words with random `s_valid` gaps.
  - All 20 emerge in order.
  - `level` never exceeds 4; `aen` spacing is never below 6.
- **Simultaneous push/launch at level 2:** `level` stays 2, and the launched word is the older one.
- **Reset mid-burst:** assert `arst_n` low while `level`=3.
  - All outputs are zero asynchronously.
  - After release, no `aen` occurs until a new push.
- **ACK mode (macro defined):**
  - Withhold `back_tgl`: the second word does not launch even after 100 cycles.
  - Toggle `back_tgl`: the second `aen` follows 3–4 cycles later, provided the gap has expired.

Source files
------------

// File: rtl/cdc_mcp_pacer.sv
// cdc_mcp_pacer: source-side pacer for a synchronized-enable-pulse MCP crossing.
// Buffers a valid/ready word stream in a small FIFO and launches one word at a
// time onto adata/aen, with at least GAP cycles between aen pulses so that the
// destination always samples settled data.
// Optional macro CDC_MCP_PACER_ACK_EN: each launch additionally waits for the
// returned acknowledge toggle (back_tgl) before the next launch is permitted.
module cdc_mcp_pacer #(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    parameter int GAP   = 6
) (
    input  logic                     aclk,
    input  logic                     arst_n,
    input  logic [DW-1:0]            s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic [DW-1:0]            adata,
    output logic                     aen,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     inflight
`ifdef CDC_MCP_PACER_ACK_EN
    ,
    input  logic                     back_tgl
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (GAP > 2) ? $clog2(GAP) : 1;

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic          r_ready;
    logic [DW-1:0] r_adata;
    logic          r_aen;
    logic [CW-1:0] r_gap_cnt;

    logic          w_empty;
    logic          w_push;
    logic          w_launch;
    logic          w_busy;
    logic [AW:0]   w_wr_ptr_next;
    logic [AW:0]   w_rd_ptr_next;
    logic          w_full_next;

    // Full/empty come from the extra pointer MSB; a launch only ever sees
    // words written on earlier edges, so there is no fall-through.
    assign w_empty       = (r_wr_ptr == r_rd_ptr);
    assign w_push        = s_valid && r_ready;
    assign w_launch      = !w_empty && (r_gap_cnt == '0) && !w_busy;
    assign w_wr_ptr_next = r_wr_ptr + (AW+1)'(w_push);
    assign w_rd_ptr_next = r_rd_ptr + (AW+1)'(w_launch);
    assign w_full_next   = (w_wr_ptr_next[AW] != w_rd_ptr_next[AW]) &&
                           (w_wr_ptr_next[AW-1:0] == w_rd_ptr_next[AW-1:0]);

    // FIFO storage write; no reset so it can map onto RAM.
    always_ff @(posedge aclk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= s_data;
        end
    end

    // Pointers and registered ready; ready follows the post-edge fill state,
    // so a slot freed by a launch only opens up on the following cycle.
    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_ready  <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_ptr_next;
            r_rd_ptr <= w_rd_ptr_next;
            r_ready  <= !w_full_next;
        end
    end

    // Launch register: head word into adata, one-cycle aen pulse.
    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            r_adata <= '0;
            r_aen   <= 1'b0;
        end else begin
            r_aen <= w_launch;
            if (w_launch) begin
                r_adata <= r_mem[r_rd_ptr[AW-1:0]];
            end
        end
    end

    // Gap counter: reloads on launch, counts down to zero and stays there.
    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            r_gap_cnt <= '0;
        end else if (w_launch) begin
            r_gap_cnt <= CW'(GAP - 1);
        end else if (r_gap_cnt != '0) begin
            r_gap_cnt <= r_gap_cnt - 1'b1;
        end
    end

`ifdef CDC_MCP_PACER_ACK_EN
    logic r_sync1;
    logic r_sync2;
    logic r_ack_seen;
    logic r_busy;

    // Two-flop synchronizer for the returned toggle, plus busy tracking.
    // Any toggle change is absorbed into ack_seen; it only clears busy
    // when a launch is outstanding.
    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_ack_seen <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_sync1    <= back_tgl;
            r_sync2    <= r_sync1;
            r_ack_seen <= r_sync2;
            if (w_launch) begin
                r_busy <= 1'b1;
            end else if (r_busy && (r_sync2 != r_ack_seen)) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign w_busy = r_busy;
`else
    assign w_busy = 1'b0;
`endif

    assign s_ready  = r_ready;
    assign adata    = r_adata;
    assign aen      = r_aen;
    assign level    = r_wr_ptr - r_rd_ptr;
    assign inflight = (r_gap_cnt != '0) || w_busy;

endmodule

// File: tb/tb_cdc_mcp_pacer.sv
// Self-checking bench for cdc_mcp_pacer: randomized streams compared against a
// queue-based reference model, plus directed reset, burst and ACK scenarios.
module tb_cdc_mcp_pacer;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int GAP   = 6;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          aclk = 1'b0;
    logic          arst_n = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] adata;
    logic          aen;
    logic [LW-1:0] level;
    logic          inflight;
`ifdef CDC_MCP_PACER_ACK_EN
    logic          back_tgl = 1'b0;
`endif

    int n_vec = 0;
    int n_err = 0;

    cdc_mcp_pacer #(.DW(DW), .DEPTH(DEPTH), .GAP(GAP)) dut (
        .aclk     (aclk),
        .arst_n   (arst_n),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .adata    (adata),
        .aen      (aen),
        .level    (level),
        .inflight (inflight)
`ifdef CDC_MCP_PACER_ACK_EN
        ,
        .back_tgl (back_tgl)
`endif
    );

    always #5 aclk = ~aclk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a word queue plus "edges since the last launch".
    // A launch takes the oldest word queued before the edge once GAP edges
    // have elapsed; pushes are honoured only if the pre-edge ready was high.
    int            m_q[$];
    bit            m_ready = 1'b0;
    bit            m_aen = 1'b0;
    logic [DW-1:0] m_adata = '0;
    int            m_since = GAP;

    initial begin
        forever begin
            @(posedge aclk or negedge arst_n);
            if (!arst_n) begin
                m_q.delete();
                m_ready = 1'b0;
                m_aen   = 1'b0;
                m_adata = '0;
                m_since = GAP;
            end else begin
                automatic bit do_push = s_valid && m_ready;
                automatic bit do_launch;
                automatic logic [DW-1:0] in_word = s_data;
                if (m_since < GAP) m_since++;
                do_launch = (m_q.size() > 0) && (m_since >= GAP);
                if (do_launch) begin
                    m_adata = DW'(m_q.pop_front());
                    m_since = 0;
                end
                m_aen = do_launch;
                if (do_push) m_q.push_back(int'(in_word));
                m_ready = (m_q.size() < DEPTH);
            end
        end
    end

    // Per-cycle comparison against the model, sampled mid-cycle.
    bit chk_en = 1'b0;
    int cyc = 0;
    int last_aen = -1;
    int aen_cnt = 0;

    always @(negedge aclk) begin
        cyc++;
        if (!arst_n) last_aen = -1;
        if (aen) aen_cnt++;
        if (chk_en) begin
            check_val("aen", 32'(aen), 32'(m_aen));
            check_val("adata", 32'(adata), 32'(m_adata));
            check_val("level", 32'(level), 32'(m_q.size()));
            check_val("s_ready", 32'(s_ready), 32'(m_ready));
            check_val("inflight", 32'(inflight), 32'(m_since < GAP - 1));
            if (aen && last_aen >= 0) check_val("aen_spacing_ok", 32'(cyc - last_aen >= GAP), 32'd1);
        end
        if (aen) last_aen = cyc;
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge aclk);
            s_valid = 1'b0;
        end
    endtask

    // Offer n words (base, base+1, ...) with valid asserted pct% of cycles.
    // Returns how many words had been accepted when s_ready first went low.
    task automatic stream(input int n, input int pct, input int base, output int acc_at_full);
        int idx;
        int budget;
        bit rdy;
        idx = 0;
        budget = 0;
        acc_at_full = -1;
        while (idx < n && budget < 2000) begin
            @(negedge aclk);
            budget++;
            if (!s_ready && acc_at_full < 0 && idx > 0) acc_at_full = idx;
            s_valid = ($urandom_range(99) < pct);
            s_data  = DW'(base + idx);
            rdy     = s_ready;
            @(posedge aclk);
            if (s_valid && rdy) idx++;
        end
        if (idx < n) check_val("stream_budget", 32'(idx), 32'(n));
        @(negedge aclk);
        s_valid = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check_val({tag, "_aen"}, 32'(aen), 32'd0);
        check_val({tag, "_adata"}, 32'(adata), 32'd0);
        check_val({tag, "_level"}, 32'(level), 32'd0);
        check_val({tag, "_inflight"}, 32'(inflight), 32'd0);
        check_val({tag, "_s_ready"}, 32'(s_ready), 32'd0);
    endtask

    initial begin
        int acc;
        int cnt;
        bit seen;

        #1;
        check_zero_outputs("reset");
        repeat (2) @(negedge aclk);
        #2 arst_n = 1'b1;

`ifndef CDC_MCP_PACER_ACK_EN
        chk_en = 1'b1;

        // Single word accepted at the third edge after release.
        @(negedge aclk);
        @(negedge aclk);
        s_valid = 1'b1;
        s_data  = 8'hA5;
        @(negedge aclk);
        s_valid = 1'b0;
        aen_cnt = 0;
        idle(15);
        check_val("single_aen_count", 32'(aen_cnt), 32'd1);
        check_val("single_adata", 32'(adata), 32'hA5);
        check_val("single_level", 32'(level), 32'd0);

        // Continuous burst 0x01..0x08.
        stream(8, 100, 1, acc);
        check_val("burst_accept_before_full", 32'(acc), 32'(DEPTH + 1));
        idle(60);

        // Random-gap stream across pointer wrap.
        stream(20, 50, 8'h40, acc);
        idle(60);
        check_val("wrap_drained_level", 32'(level), 32'd0);

        // Reset while three words are queued.
        cnt = 0;
        s_valid = 1'b0;
        while (m_q.size() != 3 && cnt < 50) begin
            @(negedge aclk);
            cnt++;
            s_valid = m_ready;
            s_data  = DW'($urandom);
        end
        check_val("pre_reset_level", 32'(level), 32'd3);
        s_valid = 1'b0;
        #2 arst_n = 1'b0;
        #1 check_zero_outputs("mid_reset");
        @(negedge aclk);
        #2 arst_n = 1'b1;
        aen_cnt = 0;
        idle(20);
        check_val("post_reset_no_aen", 32'(aen_cnt), 32'd0);

        // One more random stream after reset.
        stream(12, 70, 8'h80, acc);
        idle(60);
`else
        // ACK mode: two words, second must wait for the returned toggle.
        @(negedge aclk);
        s_valid = 1'b1;
        s_data  = 8'h11;
        @(negedge aclk);
        s_data  = 8'h22;
        @(negedge aclk);
        s_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (aen) seen = 1'b1;
            else @(negedge aclk);
        end
        check_val("ack_first_aen", 32'(seen), 32'd1);
        check_val("ack_first_adata", 32'(adata), 32'h11);
        aen_cnt = 0;
        idle(100);
        check_val("ack_withheld_no_aen", 32'(aen_cnt), 32'd0);
        check_val("ack_withheld_level", 32'(level), 32'd1);
        back_tgl = ~back_tgl;
        cnt = 0;
        seen = 1'b0;
        while (!seen && cnt < 20) begin
            @(negedge aclk);
            cnt++;
            if (aen) seen = 1'b1;
        end
        check_val("ack_second_latency_ok", 32'(seen && cnt >= 3 && cnt <= 4), 32'd1);
        check_val("ack_second_adata", 32'(adata), 32'h22);
        idle(10);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
